// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side memory responder: word RAM plus MMIO console TX FIFO and timer
// Optional timer: define DMEM_TIMER_EN to build mtime/mtimecmp and timer_irq.
module dmem_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  // Address decode
  logic          ram_hit;
  logic          mmio_hit;
  logic [1:0]    mmio_off;
  logic [AW-1:0] ram_idx;

  assign ram_hit  = (Addr < RAM_BYTES);
  assign mmio_hit = (Addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = Addr[3:2];
  assign ram_idx  = Addr[AW+1:2];

  logic wr_txdata;
  logic wr_status;
  logic wr_mtimecmp;

  assign wr_txdata   = MemWrite & mmio_hit & (mmio_off == 2'd0);
  assign wr_status   = MemWrite & mmio_hit & (mmio_off == 2'd1);
  assign wr_mtimecmp = MemWrite & mmio_hit & (mmio_off == 2'd3);

  // Word RAM: no reset so contents survive a reset pulse
  logic [31:0] ram_q [RAM_WORDS];

  // RAM store commits on the clock edge; loads in the same cycle see the old word
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) begin
      ram_q[ram_idx] <= WriteData;
    end
  end

  // Console TX FIFO
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          push_drop;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign tx_valid  = ~empty;
  assign tx_data   = fifo_q[rd_ptr_q];
  assign pop       = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot the push needs, so full only drops without a pop
  assign push_ok   = wr_txdata & (~full | pop);
  assign push_drop = wr_txdata & full & ~pop;

  // FIFO next-state: pointers, occupancy and sticky overflow (set beats clear)
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
    if (wr_status && WriteData[1]) begin
      ovf_d = 1'b0;
    end
    if (push_drop) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO state registers; reset discards queued bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= WriteData[7:0];
      end
    end
  end

  // Timer
  logic [31:0] mtime_rd;
  logic [31:0] mtimecmp_rd;

`ifdef DMEM_TIMER_EN
  logic [31:0] mtime_q;
  logic [31:0] mtimecmp_q, mtimecmp_d;

  // Compare register takes a store to its offset, otherwise holds
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_mtimecmp) begin
      mtimecmp_d = WriteData;
    end
  end

  // Free-running counter and compare register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= 32'hFFFF_FFFF;
    end else begin
      mtime_q    <= mtime_q + 32'd1;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtime_rd    = mtime_q;
  assign mtimecmp_rd = mtimecmp_q;
  assign timer_irq   = (mtime_q >= mtimecmp_q);
`else
  logic unused_timer;

  assign unused_timer = wr_mtimecmp;
  assign mtime_rd     = '0;
  assign mtimecmp_rd  = '0;
  assign timer_irq    = 1'b0;
`endif

  // Load data mux: RAM, MMIO page, or zero for unmapped addresses
  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        2'd1: begin
          ReadData          = '0;
          ReadData[0]       = timer_irq;
          ReadData[1]       = ovf_q;
          ReadData[2]       = empty;
          ReadData[3]       = full;
          ReadData[4 +: CW] = count_q;
        end
        2'd2:    ReadData = mtime_rd;
        2'd3:    ReadData = mtimecmp_rd;
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (RAM, TX FIFO, timer, reset)
module tb_dmem_responder;

`ifdef DMEM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [31:0] A_TXD  = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_MT   = 32'h8000_0008;
  localparam logic [31:0] A_MTC  = 32'h8000_000C;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  sb_q [$];
  logic [31:0] exp_mtime;

  dmem_responder dut (
    .clk      (clk),
    .reset    (rst),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter for mtime
  always @(posedge clk or posedge rst) begin
    if (rst) exp_mtime <= '0;
    else     exp_mtime <= exp_mtime + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
    Addr = a;
    #1;
    check(name, ReadData, e);
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    if (accepted) sb_q.push_back(b);
    wr(A_TXD, {24'h0, b});
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int k = 0; k < 12 && tx_valid; k++) begin
      if (sb_q.size() == 0) begin
        check("tx_extra", {31'h0, tx_valid}, 32'h0);
        break;
      end
      check("tx_order", {24'h0, tx_data}, {24'h0, sb_q.pop_front()});
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    check("drained_valid", {31'h0, tx_valid}, 32'h0);
    check("sb_empty", sb_q.size(), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    MemWrite  = 1'b0;
    Addr      = '0;
    WriteData = '0;
    tx_ready  = 1'b0;

    // Reset state
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    rd("rst_status", A_STAT, 32'h4);
    rd("rst_mtimecmp", A_MTC, TIMER_EN ? 32'hFFFF_FFFF : 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // RAM store/load and read-during-write
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_load", 32'h10, 32'hDEAD_BEEF);
    rd("ram_load_unaligned", 32'h13, 32'hDEAD_BEEF);
    wr(32'h20, 32'h1111_1111);
    MemWrite  = 1'b1;
    WriteData = 32'h2222_2222;
    rd("rdw_old", 32'h20, 32'h1111_1111);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    rd("rdw_new", 32'h20, 32'h2222_2222);

    // Unmapped and out-of-range addresses
    wr(32'h0, 32'h1234_5678);
    rd("unmapped_read", 32'h4000_0000, 32'h0);
    wr(32'h4000_0000, 32'hCAFE_F00D);
    rd("unmapped_no_alias", 32'h0, 32'h1234_5678);
    wr(32'h100, 32'hBAD0_BAD0);
    rd("ram_edge_no_alias", 32'h0, 32'h1234_5678);
    rd("ram_edge_read", 32'h100, 32'h0);
    rd("txdata_reads0", A_TXD, 32'h0);

    // FIFO fill past full with the sink stalled
    MemWrite  = 1'b1;
    Addr      = A_TXD;
    WriteData = 32'h41;
    sb_q.push_back(8'h41);
    #1;
    check("no_bypass", {31'h0, tx_valid}, 32'h0);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    check("valid_after_push", {31'h0, tx_valid}, 32'h1);
    check("head_after_push", {24'h0, tx_data}, 32'h41);
    for (int i = 1; i < 5; i++) push(8'(8'h41 + i), i < 4);
    rd("status_full_ovf", A_STAT, 32'h4A);
    wr(A_STAT, 32'h2);
    rd("status_ovf_clr", A_STAT, 32'h48);
    drain();
    rd("status_after_drain", A_STAT, 32'h4);

    // Push into a full FIFO while it pops
    for (int i = 0; i < 4; i++) push(8'(8'h51 + i), 1'b1);
    rd("status_full", A_STAT, 32'h48);
    check("head_51", {24'h0, tx_data}, {24'h0, sb_q.pop_front()});
    MemWrite  = 1'b1;
    Addr      = A_TXD;
    WriteData = 32'h55;
    tx_ready  = 1'b1;
    sb_q.push_back(8'h55);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    tx_ready = 1'b0;
    rd("status_push_pop_full", A_STAT, 32'h48);
    drain();

    // Reset while bytes are queued
    for (int i = 0; i < 3; i++) push(8'(8'h61 + i), 1'b1);
    check("queued_valid", {31'h0, tx_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", {31'h0, tx_valid}, 32'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd("status_after_reset", A_STAT, 32'h4);
    rd("ram_kept", 32'h10, 32'hDEAD_BEEF);
    check("tx_data_after_reset", {24'h0, tx_data}, 32'h0);

    // Timer compare
    wr(A_MTC, 32'd20);
    for (int c = 0; c < 30; c++) begin
      check("irq_track", {31'h0, timer_irq}, {31'h0, TIMER_EN && (exp_mtime >= 32'd20)});
      @(posedge clk);
      #1;
    end
    rd("status_irq", A_STAT, TIMER_EN ? 32'h5 : 32'h4);
    rd("mtime_read", A_MT, TIMER_EN ? exp_mtime : 32'h0);
    MemWrite  = 1'b1;
    Addr      = A_MTC;
    WriteData = 32'hFFFF_FFFF;
    #1;
    check("irq_before_cmp_write", {31'h0, timer_irq}, {31'h0, TIMER_EN});
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    check("irq_after_cmp_write", {31'h0, timer_irq}, 32'h0);
    rd("mtimecmp_read", A_MTC, TIMER_EN ? 32'hFFFF_FFFF : 32'h0);
    wr(A_MT, 32'h0);
    rd("mtime_ro", A_MT, TIMER_EN ? exp_mtime : 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
